// File: rtl/mp_add_seq.sv
// mp_add_seq: multi-precision add/subtract sequencer.
//
// Computes A+B or A-B on N = WIDTH*WORDS bit operands using one WIDTH-bit
// carry-lookahead slice, least-significant word first, one slice per clock.
// The carry between slices is held in a register.
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   Start  - request an operation; accepted when Busy = 0
//   Sub    - 0: A+B, 1: A-B (sampled with Start)
//   A, B   - N-bit operands (sampled with Start)
//   Busy   - high while slices are being computed
//   Done   - one-cycle pulse, result complete
//   Sum    - N-bit result register
//   Cout   - carry out of bit N-1 (on subtract, 1 = no borrow)
//   Ovf    - two's-complement signed overflow of the result

module cla #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic             carry;

    // Generate/propagate recurrence; synthesis flattens the carry chain
    // into a lookahead tree.
    always_comb begin
        g     = a & b;
        p     = a ^ b;
        carry = cin;
        sum   = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            sum[i] = p[i] ^ carry;
            carry  = g[i] | (p[i] & carry);
        end
        cout = carry;
    end
endmodule

module mp_add_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   Start,
    input  logic                   Sub,
    input  logic [WIDTH*WORDS-1:0] A,
    input  logic [WIDTH*WORDS-1:0] B,
    output logic                   Busy,
    output logic                   Done,
    output logic [WIDTH*WORDS-1:0] Sum,
    output logic                   Cout,
    output logic                   Ovf
);
    localparam int unsigned N     = WIDTH * WORDS;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [N-1:0]     opa_q, opa_d;
    logic [N-1:0]     opb_q, opb_d;
    logic [N-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] slice_a;
    logic [WIDTH-1:0] slice_b;
    logic [WIDTH-1:0] slice_sum;
    logic             slice_cout;

    // Word-select mux feeding the single slice adder.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int unsigned w = 0; w < WORDS; w++) begin
            if (idx_q == IDX_W'(w)) begin
                slice_a = opa_q[w*WIDTH +: WIDTH];
                slice_b = opb_q[w*WIDTH +: WIDTH];
            end
        end
    end

    cla #(
        .WIDTH(WIDTH)
    ) u_cla (
        .a   (slice_a),
        .b   (slice_b),
        .cin (carry_q),
        .sum (slice_sum),
        .cout(slice_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    // Subtract as A + ~B + 1: invert B here, inject the +1
                    // through the initial carry.
                    opa_d   = A;
                    opb_d   = B ^ {N{Sub}};
                    carry_d = Sub;
                    idx_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                for (int unsigned w = 0; w < WORDS; w++) begin
                    if (idx_q == IDX_W'(w)) begin
                        sum_d[w*WIDTH +: WIDTH] = slice_sum;
                    end
                end
                carry_d = slice_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = slice_cout;
                    // Top bit of the new Sum is the top bit of this slice.
                    ovf_d   = (opa_q[N-1] == opb_q[N-1]) &&
                              (slice_sum[WIDTH-1] != opa_q[N-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Busy = (state_q == RUN);
    assign Done = (state_q == DONE);
    assign Sum  = sum_q;
    assign Cout = cout_q;
    assign Ovf  = ovf_q;
endmodule

// File: tb/tb_mp_add_seq.sv
// tb_mp_add_seq: directed bench for mp_add_seq with WIDTH = 8, WORDS = 4.
// Vector table for the arithmetic, hand sequences for handshake and reset.

module tb_mp_add_seq;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned WORDS = 4;
    localparam int unsigned N     = WIDTH * WORDS;

    logic         clk;
    logic         rst_n;
    logic         Start;
    logic         Sub;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Busy;
    logic         Done;
    logic [N-1:0] Sum;
    logic         Cout;
    logic         Ovf;

    int n_checks = 0;
    int n_fail   = 0;

    mp_add_seq #(
        .WIDTH(WIDTH),
        .WORDS(WORDS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .Start(Start),
        .Sub  (Sub),
        .A    (A),
        .B    (B),
        .Busy (Busy),
        .Done (Done),
        .Sum  (Sum),
        .Cout (Cout),
        .Ovf  (Ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Presents operands at a falling edge, holds Start across one rising
    // edge (E0) and returns #1 after it.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
        @(negedge clk);
        A     = a;
        B     = b;
        Sub   = sub;
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
    endtask

    // Called #1 after E0; returns #1 after the edge that raised Done.
    task automatic wait_done(output int cycles, output int busy_cycles);
        cycles      = 0;
        busy_cycles = 0;
        while (Done !== 1'b1 && cycles < 20) begin
            if (Busy === 1'b1) busy_cycles++;
            @(posedge clk);
            #1;
            cycles++;
        end
        check("done_within_budget", 32'(cycles < 20), 32'd1);
    endtask

    initial begin
        int   cyc;
        int   bcyc;
        logic seen_busy;
        logic seen_done;

        vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[3] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
        vecs[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[6] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
        vecs[7] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[8] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[9] = '{32'h8000_0000, 32'h8000_0001, 1'b0, 32'h0000_0001, 1'b1, 1'b1};

        rst_n = 1'b0;
        Start = 1'b0;
        Sub   = 1'b0;
        A     = '0;
        B     = '0;

        // Reset state, before any clock edge.
        #1;
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_sum",  Sum,       32'd0);
        check("rst_cout", 32'(Cout), 32'd0);
        check("rst_ovf",  32'(Ovf),  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Arithmetic vectors with latency/Busy width checks.
        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].sub);
            wait_done(cyc, bcyc);
            check($sformatf("v%0d_latency", i), 32'(cyc), 32'd4);
            check($sformatf("v%0d_busy_cycles", i), 32'(bcyc), 32'd4);
            check($sformatf("v%0d_busy_in_done", i), 32'(Busy), 32'd0);
            check($sformatf("v%0d_sum", i), Sum, vecs[i].sum);
            check($sformatf("v%0d_cout", i), 32'(Cout), 32'(vecs[i].cout));
            check($sformatf("v%0d_ovf", i), 32'(Ovf), 32'(vecs[i].ovf));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_pulse", i), 32'(Done), 32'd0);
            check($sformatf("v%0d_sum_hold", i), Sum, vecs[i].sum);
        end

        // Start held high through RUN, operands changed after acceptance.
        @(negedge clk);
        A     = 32'h0101_0101;
        B     = 32'h0202_0202;
        Sub   = 1'b0;
        Start = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) begin
            @(negedge clk);
            A   = $urandom;
            B   = $urandom;
            Sub = ~Sub;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        Start = 1'b0;
        @(posedge clk);
        #1;
        check("hold_done", 32'(Done), 32'd1);
        check("hold_sum",  Sum,       32'h0303_0303);
        check("hold_cout", 32'(Cout), 32'd0);
        check("hold_ovf",  32'(Ovf),  32'd0);
        seen_busy = 1'b0;
        seen_done = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (Busy === 1'b1) seen_busy = 1'b1;
            if (Done === 1'b1) seen_done = 1'b1;
        end
        check("hold_no_extra_busy", 32'(seen_busy), 32'd0);
        check("hold_no_extra_done", 32'(seen_done), 32'd0);
        check("hold_sum_kept", Sum, 32'h0303_0303);

        // Back-to-back: second Start in the Done cycle.
        start_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
        wait_done(cyc, bcyc);
        check("b2b_first_sum", Sum, 32'h0000_0100);
        @(negedge clk);
        A     = 32'h0000_0007;
        B     = 32'h0000_0005;
        Sub   = 1'b1;
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        cyc = 1;
        while (Done !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("b2b_done_spacing", 32'(cyc), 32'd5);
        check("b2b_second_sum",  Sum,       32'h0000_0002);
        check("b2b_second_cout", 32'(Cout), 32'd1);

        // Leave a result with nonzero Sum, Cout and Ovf before the reset test.
        start_op(32'h8000_0000, 32'h8000_0001, 1'b0);
        wait_done(cyc, bcyc);
        check("pre_rst_ovf", 32'(Ovf), 32'd1);

        // Reset asserted in the second RUN cycle.
        start_op(32'h1111_1111, 32'h2222_2222, 1'b0);
        @(posedge clk);
        #1;
        check("mid_busy_before_rst", 32'(Busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(Busy), 32'd0);
        check("midrst_done", 32'(Done), 32'd0);
        check("midrst_sum",  Sum,       32'd0);
        check("midrst_cout", 32'(Cout), 32'd0);
        check("midrst_ovf",  32'(Ovf),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_busy = 1'b0;
        seen_done = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (Busy === 1'b1) seen_busy = 1'b1;
            if (Done === 1'b1) seen_done = 1'b1;
        end
        check("postrst_busy", 32'(seen_busy), 32'd0);
        check("postrst_done", 32'(seen_done), 32'd0);
        check("postrst_sum",  Sum,            32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mp_add_seq.md
# mp_add_seq

Multi-precision add/subtract sequencer built around a single `CLA` slice of `WIDTH` bits. It processes `WORDS` slices of an `N = WIDTH*WORDS`-bit operand pair, least-significant word first, one slice per clock, and carries between slices through a registered carry. It sits beside the FP datapath wherever a wide integer add or subtract is needed, such as mantissa alignment sums or exponent arithmetic on wide formats, and trades latency for one narrow adder instead of an `N`-bit one.

## Interface
- `WIDTH`, 32, bit width of the single `CLA` instance (one slice).
- `WORDS`, 4, number of slices per operation. `WORDS >= 1`. Total operand width `N = WIDTH*WORDS`.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `Start` input 1: request a new operation; accepted only when `Busy = 0`.
- `Sub` input 1: 0 computes A+B, 1 computes A−B; sampled with `Start`.
- `A` input N: operand A; sampled with `Start`.
- `B` input N: operand B; sampled with `Start`.
- `Busy` output 1: high while slices are being computed.
- `Done` output 1: single-cycle pulse; the result is complete.
- `Sum` output N: result register.
- `Cout` output 1: carry out of bit N−1. On subtract, 1 means no borrow (A ≥ B unsigned).
- `Ovf` output 1: two's-complement signed overflow of the N-bit result.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE**, `Busy = 0`:
  - `Start = 1` latches `A` into `opA`.
  - It latches `B ^ {N{Sub}}` into `opB`.
  - It sets the carry register to `Sub` and the slice index to 0, then goes to RUN.
- **RUN**, `Busy = 1`:
  - The `CLA` adds `opA[idx]`, `opB[idx]` and the carry register.
  - On the edge, `Sum` word `idx` takes the slice sum and the carry register takes the slice `Cout`.
  - When `idx = WORDS−1`, the FSM loads `Cout`, computes `Ovf`, and goes to DONE. Otherwise `idx` increments.
- **DONE**, `Busy = 0`, `Done = 1`:
  - `Start = 1` is accepted exactly as in IDLE and the FSM goes to RUN (back-to-back operation).
  - Otherwise the FSM goes to IDLE.
- `Ovf = (opA[N−1] == opB[N−1]) && (Sum[N−1] != opA[N−1])`. `opB` is the already-inverted operand.
- `Sum` words are overwritten one slice per cycle during RUN. `Sum` is a valid result only in DONE and afterwards in IDLE.
- `Sum`, `Cout` and `Ovf` hold their values until the next accepted `Start` leads to RUN edges.
- `Cout` and `Ovf` change only on the final RUN edge.
- `Start` in RUN is ignored, with no queuing.
- `A`, `B` and `Sub` are ignored except at the acceptance edge. Changes during RUN do not affect the result.
- `WORDS = 1`: RUN lasts exactly one cycle. The index register is at least 1 bit wide.
- Only one `CLA` instance is permitted. Wide adds go through it, never a behavioural `+` of width N.

## Timing
- **Reset** (`rst_n` low, asynchronous):
  - State becomes IDLE; `idx` and the carry register become 0.
  - `Busy = 0`, `Done = 0`, `Sum = 0`, `Cout = 0`, `Ovf = 0`.
  - Takes effect immediately, without waiting for a clock edge.
- **Reset mid-RUN**: the operation is aborted, no `Done` is produced, and after release the FSM waits in IDLE.
- **Latency**: for `Start` sampled at edge E0, `Busy` is high from E0 through E`WORDS`. `Done` is high for the single cycle following edge E`WORDS`.
- **Throughput**: one operation per `WORDS+1` cycles when `Start` is asserted in the DONE cycle.
- **Combinational depth**: one `WIDTH`-bit `CLA` plus word-select muxing.

## Test plan
Bench configuration: `WIDTH = 8`, `WORDS = 4` (N = 32).
- **Single carry:** `0x000000FF + 0x00000001` → `Sum = 0x00000100`, `Cout = 0`, `Ovf = 0`. `Done` pulses once, 4 cycles after the `Start` edge; `Busy` is high for exactly 4 cycles.
- **Full carry ripple:** `0xFFFFFFFF + 0x00000001` → `Sum = 0x00000000`, `Cout = 1`, `Ovf = 0`.
- **Subtract:**
  - `0x00000005 − 0x00000007` → `Sum = 0xFFFFFFFE`, `Cout = 0`.
  - `0x00000007 − 0x00000005` → `Sum = 0x00000002`, `Cout = 1`.
  - Both give `Ovf = 0`.
- **Signed overflow:**
  - `0x7FFFFFFF + 0x00000001` → `Sum = 0x80000000`, `Ovf = 1`, `Cout = 0`.
  - `0x80000000 − 0x00000001` → `Sum = 0x7FFFFFFF`, `Ovf = 1`.
- **Handshake:**
  - `Start` held high and `A`/`B` changed during RUN → the result matches the operands sampled at acceptance, and there is no extra operation.
  - A second `Start` in the `Done` cycle → the second `Done` arrives exactly 5 cycles after the first.
- **Reset mid-operation:** assert `rst_n = 0` in the second RUN cycle → all outputs are 0 immediately. After release with `Start = 0`, `Done` never pulses and `Busy` stays 0.
